mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single 128-bit line-fill/write-back port of `datamem` between an instruction-side requester (`icache`, read-only) and the data-side requester (`cache`). It sits between the two caches and `datamem`. It grants one requester at a time and holds the request fields for the whole transaction. It routes `mem_ready`/`mem_readdata` back to the granted requester only.

## Interface
- `ADDR_WIDTH`, 32, byte address width of all address ports
- `LINE_WIDTH`, 128, line data width
- `clk` input 1 — clock
- `rst` input 1 — synchronous, active-high reset
- `i_mem_req` input 1 — icache line-read request, level, held until `i_mem_ready`
- `i_memory_address` input ADDR_WIDTH — icache line address
- `i_mem_readdata` output LINE_WIDTH — read line to icache
- `i_mem_ready` output 1 — one-cycle completion pulse to icache
- `d_mem_req` input 1 — dcache request, level, held until `d_mem_ready`
- `d_WriteEnable` input 1 — 1 = write-back, 0 = line read
- `d_memory_address` input ADDR_WIDTH — dcache line address
- `d_mem_writedata` input LINE_WIDTH — write-back line
- `d_mem_readdata` output LINE_WIDTH — read line to dcache
- `d_mem_ready` output 1 — one-cycle completion pulse to dcache
- `mem_req` output 1 — request to `datamem`
- `WriteEnable` output 1 — write select to `datamem`
- `memory_address` output ADDR_WIDTH — address to `datamem`
- `mem_writedata` output LINE_WIDTH — write line to `datamem`
- `mem_readdata` input LINE_WIDTH — line from `datamem`
- `mem_ready` input 1 — completion pulse from `datamem`

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any `*_mem_req` is high, pick a winner and register the winner id, address, write data and write enable. Icache grants register `WriteEnable`=0 and `mem_writedata`=0. Then go to BUSY. With no request, stay in IDLE.
- BUSY: `mem_req`=1 and all registered fields are held constant. On `mem_ready`=1, assert the winner's `*_mem_ready` combinationally in the same cycle. Update `last_grant` to the winner and go to DONE.
- DONE: one turnaround cycle. No grant is issued and `mem_req`=0. The requester is required to drop its request in this cycle. Go to IDLE.
- Tie rule without the macro: dcache always wins.
- `*_mem_readdata` outputs are both driven from `mem_readdata`. Only the `*_mem_ready` outputs are gated by the winner id.
- `mem_ready` is ignored in IDLE and DONE; no requester ready pulse is produced.
- Request inputs are sampled only in IDLE. Changes during BUSY or DONE have no effect.

## Timing
- Reset values: state=IDLE; `mem_req`, `WriteEnable`, `i_mem_ready`, `d_mem_ready`=0; `memory_address`, `mem_writedata`=0; `last_grant`=ICACHE.
- Request-to-memory latency: a request seen high in IDLE at cycle t gives `mem_req`=1 from cycle t+1.
- Completion: `mem_ready` at cycle r gives `*_mem_ready`=1 at cycle r (zero latency). The state is DONE at r+1 and IDLE at r+2. The earliest next `mem_req` is at r+3.
- `mem_ready` may arrive in the first BUSY cycle. It is accepted.
- Reset asserted mid-BUSY aborts the transaction. `mem_req` drops the cycle after and no ready pulse is generated.
- Back-to-back requests from the same requester are served with the fixed 2-cycle gap (DONE plus IDLE decision).

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, grant the requester that is not `last_grant`. Reset `last_grant`=ICACHE, so the first tie goes to dcache.
- Undefined: fixed priority, dcache always wins ties. `last_grant` is still maintained but unused for selection.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t`
  - `typedef enum logic {GNT_I, GNT_D} arb_gnt_t`
  - `localparam LINE_WIDTH = 128`
- One combinational sub-module, `arb_select`: inputs `i_req`, `d_req`, `last_grant`; outputs `valid`, `gnt`. The priority/round-robin choice lives there under the macro. The FSM and registers stay in `mem_arbiter`.

## Test plan
- Icache read alone: `i_mem_req`=1 with address 0x0000_1000, `mem_ready` 3 cycles after `mem_req` rises, `mem_readdata`=0xA5…A5 → `memory_address`=0x1000 and `WriteEnable`=0. `i_mem_ready` pulses for exactly one cycle with `i_mem_readdata`=0xA5…A5. `d_mem_ready` never rises.
- Dcache write-back alone: `d_WriteEnable`=1, address 0x0001_0040, data 0x1122…FF → identical values appear on the `datamem` port and are held until `mem_ready`. `d_mem_ready` pulses once.
- Simultaneous requests, twice in a row, macro off → dcache is served both times; icache waits.
- Simultaneous requests, twice in a row, macro on → dcache is served first, icache second.
- Spurious `mem_ready` in IDLE → no `*_mem_ready` pulse and the state stays IDLE.
- `rst` asserted during BUSY → next cycle: IDLE, `mem_req`=0, `last_grant`=ICACHE. A later `mem_ready` produces no pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the icache/dcache memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned LINE_WIDTH = 128;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} arb_gnt_t;

endpackage

// File: rtl/arb_select.sv
// Winner selection between icache and dcache requests.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester that was not granted last.
module arb_select
    import mem_arb_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  arb_gnt_t last_grant,
    output logic     valid,
    output arb_gnt_t gnt
);

    assign valid = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt = GNT_D;
        if (i_req && d_req) begin
            gnt = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
            gnt = GNT_I;
        end
    end
`else
    // Fixed priority: history is kept by the arbiter but not consulted here.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == GNT_D);

    always_comb begin
        gnt = GNT_D;
        if (i_req && !d_req) begin
            gnt = GNT_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the datamem line port between icache (read-only) and dcache.
// Optional round-robin tie breaking via MEM_ARB_ROUND_ROBIN_EN (see arb_select).
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = mem_arb_pkg::LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_req,
    input  logic [ADDR_WIDTH-1:0] i_memory_address,
    output logic [LINE_WIDTH-1:0] i_mem_readdata,
    output logic                  i_mem_ready,
    input  logic                  d_mem_req,
    input  logic                  d_WriteEnable,
    input  logic [ADDR_WIDTH-1:0] d_memory_address,
    input  logic [LINE_WIDTH-1:0] d_mem_writedata,
    output logic [LINE_WIDTH-1:0] d_mem_readdata,
    output logic                  d_mem_ready,
    output logic                  mem_req,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [LINE_WIDTH-1:0] mem_writedata,
    input  logic [LINE_WIDTH-1:0] mem_readdata,
    input  logic                  mem_ready
);
    import mem_arb_pkg::*;

    arb_state_t            state_q, state_d;
    arb_gnt_t              gnt_q, gnt_d;
    arb_gnt_t              last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  sel_valid;
    arb_gnt_t              sel_gnt;

    arb_select u_select (
        .i_req      (i_mem_req),
        .d_req      (d_mem_req),
        .last_grant (last_grant_q),
        .valid      (sel_valid),
        .gnt        (sel_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sel_valid) state_d = BUSY;
            BUSY:    if (mem_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is zero-latency from mem_ready; suppressed while reset aborts the transfer.
    always_comb begin
        mem_req     = 1'b0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        if (state_q == BUSY) begin
            mem_req = 1'b1;
            if (mem_ready && !rst) begin
                i_mem_ready = (gnt_q == GNT_I);
                d_mem_ready = (gnt_q == GNT_D);
            end
        end
    end

    // Request fields are captured once in IDLE and held for the whole transfer.
    always_comb begin
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && sel_valid) begin
            gnt_d = sel_gnt;
            if (sel_gnt == GNT_D) begin
                addr_d  = d_memory_address;
                wdata_d = d_mem_writedata;
                we_d    = d_WriteEnable;
            end else begin
                addr_d  = i_memory_address;
                wdata_d = '0;
                we_d    = 1'b0;
            end
        end
        if ((state_q == BUSY) && mem_ready) begin
            last_grant_d = gnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q        <= GNT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            last_grant_q <= GNT_I;
        end else begin
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign memory_address = addr_q;
    assign mem_writedata  = wdata_q;
    assign WriteEnable    = we_q;
    assign i_mem_readdata = mem_readdata;
    assign d_mem_readdata = mem_readdata;

endmodule
